// File: rtl/ud_counter_param_pkg.sv
// Purpose: shared 7-segment glyph constants and hex segment table for ud_counter_param.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Segment ordering for every constant: bit0=a .. bit6=g, active-high.
package ud_counter_param_pkg;

    localparam logic [6:0] SEG_U     = 7'b0111110;  // "U": b c d e f
    localparam logic [6:0] SEG_D     = 7'b1011110;  // "d": b c d e g
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Packed table indexed by nibble; the first entry written is index 15.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b1110001,  // F
        7'b1111001,  // E
        7'b1011110,  // d
        7'b0111001,  // C
        7'b1111100,  // b
        7'b1110111,  // A
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

endpackage

// File: rtl/ud_counter_param_seg7_hex_dec.sv
// Purpose: combinational 4-bit to 7-segment hex decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: nibble_i - value to show; seg_o - segments a..g on bits 0..6, active-high.
module seg7_hex_dec
    import ud_counter_param_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/ud_counter_param.sv
// Purpose: parametrised up/down counter with modulus, wrap/saturate, load, terminal-count pulse and 7-seg output.
// Latency: 1 cycle, every output registered on posedge cp.
// Backpressure: none; inputs are sampled every edge.
// Ports: cp clock; reset sync active-high; en count enable; x direction (1=up);
//        load/load_val parallel load (clamped to MODULUS-1); out count; tc terminal-count pulse;
//        display segments (direction glyph when DISP_MODE=0, hex of out[3:0] when DISP_MODE=1).
module ud_counter_param
    import ud_counter_param_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int SATURATE  = 0,
    parameter int DISP_MODE = 0
) (
    input  logic             cp,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic [6:0]       display
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [6:0]       disp_q, disp_d;

    // Next count and terminal-count: load beats enable, enable beats hold.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (x) begin
                if (count_q == MAX_VAL) begin
                    tc_d    = 1'b1;
                    count_d = (SATURATE != 0) ? count_q : '0;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = (SATURATE != 0) ? count_q : MAX_VAL;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    generate
        if (DISP_MODE == 1) begin : g_hex
            // Decode the next count so the display lands on the same edge as out.
            logic [3:0] nib_d;
            assign nib_d = 4'(count_d);
            seg7_hex_dec u_dec (
                .nibble_i (nib_d),
                .seg_o    (disp_d)
            );
        end else begin : g_glyph
            assign disp_d = x ? SEG_U : SEG_D;
        end
    endgenerate

    always_ff @(posedge cp) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            disp_q  <= SEG_BLANK;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            disp_q  <= disp_d;
        end
    end

    assign out     = count_q;
    assign tc      = tc_q;
    assign display = disp_q;

endmodule

// File: tb/tb_ud_counter_param.sv
// Purpose: self-checking bench for ud_counter_param across five parameter sets sharing one stimulus.
// Latency: outputs compared 1 ns after each rising edge.
// Backpressure: n/a.
module tb_ud_counter_param;

    logic        cp = 1'b0;
    logic        rst_s = 1'b1;
    logic        en_s = 1'b0;
    logic        x_s = 1'b1;
    logic        ld_s = 1'b0;
    logic [15:0] lv_s = '0;

    always #5 cp = ~cp;

    // Instance parameter sets: 0:W4 M16 wrap glyph, 1:W4 M10 wrap hex,
    // 2:W4 M10 sat glyph, 3:W4 M16 sat hex, 4:W3 M8 wrap hex.
    localparam int P_W   [5] = '{4, 4, 4, 4, 3};
    localparam int P_MOD [5] = '{16, 10, 10, 16, 8};
    localparam int P_SAT [5] = '{0, 0, 1, 1, 0};
    localparam int P_DM  [5] = '{0, 1, 0, 1, 1};

    logic [3:0] out0, out1, out2, out3;
    logic [2:0] out4;
    logic       tc0, tc1, tc2, tc3, tc4;
    logic [6:0] dsp0, dsp1, dsp2, dsp3, dsp4;

    ud_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .DISP_MODE(0)) u0 (
        .cp(cp), .reset(rst_s), .en(en_s), .x(x_s), .load(ld_s), .load_val(lv_s[3:0]),
        .out(out0), .tc(tc0), .display(dsp0));
    ud_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .DISP_MODE(1)) u1 (
        .cp(cp), .reset(rst_s), .en(en_s), .x(x_s), .load(ld_s), .load_val(lv_s[3:0]),
        .out(out1), .tc(tc1), .display(dsp1));
    ud_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .DISP_MODE(0)) u2 (
        .cp(cp), .reset(rst_s), .en(en_s), .x(x_s), .load(ld_s), .load_val(lv_s[3:0]),
        .out(out2), .tc(tc2), .display(dsp2));
    ud_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(1), .DISP_MODE(1)) u3 (
        .cp(cp), .reset(rst_s), .en(en_s), .x(x_s), .load(ld_s), .load_val(lv_s[3:0]),
        .out(out3), .tc(tc3), .display(dsp3));
    ud_counter_param #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .DISP_MODE(1)) u4 (
        .cp(cp), .reset(rst_s), .en(en_s), .x(x_s), .load(ld_s), .load_val(lv_s[2:0]),
        .out(out4), .tc(tc4), .display(dsp4));

    int d_out [5];
    int d_tc  [5];
    int d_dsp [5];
    always_comb begin
        d_out[0] = int'(out0); d_out[1] = int'(out1); d_out[2] = int'(out2);
        d_out[3] = int'(out3); d_out[4] = int'(out4);
        d_tc[0] = int'(tc0); d_tc[1] = int'(tc1); d_tc[2] = int'(tc2);
        d_tc[3] = int'(tc3); d_tc[4] = int'(tc4);
        d_dsp[0] = int'(dsp0); d_dsp[1] = int'(dsp1); d_dsp[2] = int'(dsp2);
        d_dsp[3] = int'(dsp3); d_dsp[4] = int'(dsp4);
    end

    // Independent segment references (gfedcba).
    localparam int GLYPH_U = 'h3E;
    localparam int GLYPH_D = 'h5E;
    localparam int HEX_T [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                                  'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    task automatic apply(input bit r, input bit e, input bit xx, input bit l, input int v);
        rst_s = r; en_s = e; x_s = xx; ld_s = l; lv_s = 16'(v);
        tick();
    endtask

    // Behavioural reference: counts live in 0..M-1, moves computed with plain arithmetic.
    int m_out [5];
    int m_tc  [5];
    int m_dsp [5];

    function automatic void model_step(input int k);
        int m;
        int v;
        bit sat;
        m   = P_MOD[k];
        sat = (P_SAT[k] != 0);
        v   = int'(lv_s) % (1 << P_W[k]);
        if (rst_s) begin
            m_out[k] = 0; m_tc[k] = 0; m_dsp[k] = 0;
            return;
        end
        m_tc[k] = 0;
        if (ld_s) begin
            m_out[k] = (v < m) ? v : m - 1;
        end else if (en_s) begin
            if (x_s) begin
                m_tc[k]  = (m_out[k] == m - 1) ? 1 : 0;
                m_out[k] = sat ? ((m_out[k] + 1 > m - 1) ? m - 1 : m_out[k] + 1)
                               : (m_out[k] + 1) % m;
            end else begin
                m_tc[k]  = (m_out[k] == 0) ? 1 : 0;
                m_out[k] = sat ? ((m_out[k] == 0) ? 0 : m_out[k] - 1)
                               : (m_out[k] + m - 1) % m;
            end
        end
        m_dsp[k] = (P_DM[k] != 0) ? HEX_T[m_out[k] % 16] : (x_s ? GLYPH_U : GLYPH_D);
    endfunction

    typedef struct {
        bit rst; bit en; bit x; bit ld; int lv;
        int ob; int tb; int db;   // instance 1: M10 wrap, hex display
        int oc; int tcc; int dc;  // instance 2: M10 saturate, glyph display
    } vec_t;

    vec_t vt [16];

    initial begin
        //         rst en x ld lv   outB tcB dispB   outC tcC dispC
        vt[0]  = '{1, 1, 1, 0, 0,   0, 0, 'h00,     0, 0, 'h00};
        vt[1]  = '{1, 1, 1, 0, 0,   0, 0, 'h00,     0, 0, 'h00};
        vt[2]  = '{0, 0, 1, 0, 0,   0, 0, 'h3F,     0, 0, 'h3E};
        vt[3]  = '{0, 1, 1, 0, 0,   1, 0, 'h06,     1, 0, 'h3E};
        vt[4]  = '{0, 1, 1, 1, 9,   9, 0, 'h6F,     9, 0, 'h3E};
        vt[5]  = '{0, 1, 1, 0, 0,   0, 1, 'h3F,     9, 1, 'h3E};
        vt[6]  = '{0, 1, 1, 0, 0,   1, 0, 'h06,     9, 1, 'h3E};
        vt[7]  = '{0, 1, 0, 0, 0,   0, 0, 'h3F,     8, 0, 'h5E};
        vt[8]  = '{0, 1, 0, 0, 0,   9, 1, 'h6F,     7, 0, 'h5E};
        vt[9]  = '{0, 1, 0, 1, 13,  9, 0, 'h6F,     9, 0, 'h5E};
        vt[10] = '{0, 0, 1, 0, 0,   9, 0, 'h6F,     9, 0, 'h3E};
        vt[11] = '{0, 0, 0, 0, 0,   9, 0, 'h6F,     9, 0, 'h5E};
        vt[12] = '{1, 1, 1, 1, 5,   0, 0, 'h00,     0, 0, 'h00};
        vt[13] = '{0, 1, 0, 0, 0,   9, 1, 'h6F,     0, 1, 'h5E};
        vt[14] = '{0, 1, 0, 0, 0,   8, 0, 'h7F,     0, 1, 'h5E};
        vt[15] = '{0, 0, 0, 1, 3,   3, 0, 'h4F,     3, 0, 'h5E};

        for (int i = 0; i < 16; i++) begin
            apply(vt[i].rst, vt[i].en, vt[i].x, vt[i].ld, vt[i].lv);
            chk($sformatf("vec%0d B out", i),  d_out[1], vt[i].ob);
            chk($sformatf("vec%0d B tc", i),   d_tc[1],  vt[i].tb);
            chk($sformatf("vec%0d B disp", i), d_dsp[1], vt[i].db);
            chk($sformatf("vec%0d C out", i),  d_out[2], vt[i].oc);
            chk($sformatf("vec%0d C tc", i),   d_tc[2],  vt[i].tcc);
            chk($sformatf("vec%0d C disp", i), d_dsp[2], vt[i].dc);
        end

        // Reset mid-count: instance 0 sitting at 7.
        apply(0, 0, 1, 1, 7);
        chk("A load 7", d_out[0], 7);
        apply(1, 1, 1, 1, 3);
        chk("A reset out", d_out[0], 0);
        chk("A reset tc", d_tc[0], 0);
        chk("A reset disp", d_dsp[0], 0);

        // Wrap down from 0 and glyph turnaround on instance 0.
        apply(0, 0, 1, 1, 0);
        apply(0, 1, 0, 0, 0);
        chk("A wrapdn out", d_out[0], 15);
        chk("A wrapdn tc", d_tc[0], 1);
        chk("A wrapdn disp d", d_dsp[0], GLYPH_D);
        apply(0, 0, 1, 0, 0);
        chk("A glyph U", d_dsp[0], GLYPH_U);
        chk("A hold out", d_out[0], 15);
        chk("A tc drop", d_tc[0], 0);

        // Clamped load then hold for five cycles on instance 1.
        apply(0, 1, 1, 1, 13);
        chk("B clamp", d_out[1], 9);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 1, 0, 0);
            chk($sformatf("B hold%0d", i), d_out[1], 9);
        end

        // Hex display on instance 3 (M16) and the 3-bit instance 4 (M8).
        apply(0, 0, 1, 1, 0);
        chk("D disp 0", d_dsp[3], 'h3F);
        for (int i = 0; i < 3; i++) apply(0, 1, 1, 0, 0);
        chk("D out 3", d_out[3], 3);
        chk("D disp 3", d_dsp[3], 'h4F);
        apply(0, 0, 1, 1, 9);
        chk("D disp 9", d_dsp[3], 'h6F);
        apply(0, 0, 1, 1, 15);
        chk("D disp F", d_dsp[3], 'h71);
        chk("E out 7", d_out[4], 7);
        chk("E disp 7", d_dsp[4], 'h07);
        apply(0, 1, 1, 0, 0);
        chk("D sat out", d_out[3], 15);
        chk("D sat tc", d_tc[3], 1);
        chk("E wrap out", d_out[4], 0);
        chk("E wrap tc", d_tc[4], 1);
        chk("E wrap disp", d_dsp[4], 'h3F);

        // Randomised run against the reference model.
        rst_s = 1'b1; en_s = 1'b0; ld_s = 1'b0;
        for (int k = 0; k < 5; k++) model_step(k);
        tick();
        for (int n = 0; n < 3000; n++) begin
            rst_s = ($urandom_range(0, 63) == 0);
            ld_s  = ($urandom_range(0, 7) == 0);
            en_s  = 1'($urandom_range(0, 3) != 0);
            x_s   = 1'($urandom_range(0, 1));
            lv_s  = 16'($urandom_range(0, 15));
            for (int k = 0; k < 5; k++) model_step(k);
            tick();
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("rnd%0d i%0d out", n, k),  d_out[k], m_out[k]);
                chk($sformatf("rnd%0d i%0d tc", n, k),   d_tc[k],  m_tc[k]);
                chk($sformatf("rnd%0d i%0d disp", n, k), d_dsp[k], m_dsp[k]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
